cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Instruction sequencer that drives the 20-bit `instruction` input and the reset of `simple_cpu`. It holds a small host-loaded program store, steps a program counter through it, and presents each instruction for a fixed number of clocks (the CU has no handshake). It supports run, single-step, pause and halt-on-sentinel. It sits between the host/testbench load port and the CPU top level.

## Interface
- `INSTR_WIDTH`, 20, instruction word width (matches CPU).
- `PC_BITS`, 5, program store depth is 2^PC_BITS words.
- `STEP_CYCLES`, 4, clocks each instruction is held on `instruction`; legal range 1..255.
- `HALT_WORD`, 20'hFFFFF, sentinel word that ends execution.
- `NOP_WORD`, 20'h00000, word driven when no instruction is issued.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `load_en`  in  1  write `load_data` into store at `load_addr`.
- `load_addr`  in  PC_BITS  store write address.
- `load_data`  in  INSTR_WIDTH  store write data.
- `start`  in  1  begin or resume continuous execution.
- `step`  in  1  execute exactly one instruction.
- `stop`  in  1  pause after the current instruction.
- `instruction`  out  INSTR_WIDTH  word to CPU `instruction` port.
- `cpu_rst`  out  1  reset to CPU `rst` port.
- `pc`  out  PC_BITS  address of the current or next instruction.
- `busy`  out  1  high in FETCH or EXEC.
- `done`  out  1  high in HALTED.

## Operation
- States: IDLE, FETCH, EXEC, PAUSE, HALTED. All outputs are registered.
- Program store: 2^PC_BITS x INSTR_WIDTH registers.
  - Every word resets to HALT_WORD, so unprogrammed slots halt.
  - Writes are accepted only in IDLE, PAUSE or HALTED; `load_en` is ignored in FETCH and EXEC.
- IDLE: `cpu_rst`=1, `pc`=0, `instruction`=NOP_WORD.
  - `start` -> FETCH in run mode.
  - `step` -> FETCH in single mode.
- FETCH, one cycle: read store[pc] into the instruction register.
  - Word == HALT_WORD -> HALTED; `pc` is not advanced.
  - Otherwise -> EXEC with hold counter = STEP_CYCLES-1.
- EXEC: `instruction` = latched word; counter decrements each cycle.
  - At counter 0: `pc` <= pc+1, modulo 2^PC_BITS (31 wraps to 0 and execution continues).
  - If single mode or a stop is pending -> PAUSE; else -> FETCH.
- PAUSE: `instruction`=NOP_WORD; `cpu_rst`=0, so CPU/memory state is preserved.
  - `start` -> FETCH in run mode; `step` -> FETCH in single mode. Execution continues from the current `pc`.
- HALTED: `done`=1, `instruction`=NOP_WORD, `cpu_rst`=0.
  - `start` or `step` sets `pc`=0 and goes to FETCH; CPU is not reset.
- Stop handling:
  - `stop` sampled in FETCH or EXEC sets a stop-pending flag, which is cleared on entering PAUSE.
  - `stop` in IDLE, PAUSE or HALTED is ignored.
- Priority within one cycle: `stop` > `start` > `step`.
  - A load in the same cycle as `start` is written before the following FETCH reads the store.
- `cpu_rst` is 1 only in IDLE.
- Reset mid-operation: immediately IDLE, store refilled with HALT_WORD, stop flag cleared, all outputs at reset values.

## Timing
- Reset values: `instruction`=NOP_WORD, `cpu_rst`=1, `pc`=0, `busy`=0, `done`=0.
- `start` sampled at edge N: FETCH during cycle N+1, CPU reset released from N+1.
- `instruction` is valid for cycles N+2 .. N+1+STEP_CYCLES; the next FETCH follows.
- Throughput: one instruction per STEP_CYCLES+1 clocks.
- HALT_WORD fetched in cycle F: `done`=1 from F+1; `busy` falls the same cycle.
- `pc` increments on the last EXEC edge, so it is visible in the following FETCH/PAUSE cycle.
- No combinational path from any input to any output.

## Structure
- Shared package `cpu_seq_pkg`:
  - state enum (IDLE, FETCH, EXEC, PAUSE, HALTED);
  - default HALT_WORD and NOP_WORD constants;
  - counter width constant (8 bits).
- One sub-module: `prog_store`.
  - Parameterised register array with async reset to HALT_WORD.
  - One synchronous write port and one asynchronous read port.
- FSM, hold counter, PC and stop flag live in `cpu_sequencer`.

## Test plan
- Reset with default parameters -> `cpu_rst`=1, `pc`=0, `instruction`=20'h00000, `busy`=0, `done`=0; a store read at every address returns 20'hFFFFF.
- Load 20'h12345, 20'h0ABCD, HALT_WORD at 0..2, pulse `start` -> each word held exactly 4 cycles, `pc` 0→1→2, `done`=1 one cycle after FETCH of address 2, `pc` stays 2.
- Same program, pulse `step` three times with gaps -> one word per pulse, PAUSE with NOP_WORD between pulses, HALTED after the third pulse.
- `stop` asserted in the second EXEC cycle of address 0 -> address 0 completes its 4 cycles, PAUSE with `pc`=1; `start` resumes at address 1.
- Fill all 32 slots with non-halt words, run -> `pc` wraps 31→0 and address 0 is re-issued; `load_en` during EXEC leaves the store unchanged.
- Assert `rst` mid-EXEC -> outputs return to reset values on the same edge, store reads 20'hFFFFF, and a later `start` halts at address 0.

Source files
------------

// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the instruction sequencer that feeds simple_cpu.
package cpu_seq_pkg;

    // Sequencer control states
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_PAUSE,
        S_HALTED
    } seq_state_e;

    // Width of the per-instruction hold counter (STEP_CYCLES up to 255)
    localparam int CNT_W = 8;

    // Default word encodings, sized for the 20-bit CPU instruction bus
    localparam int          DEF_INSTR_WIDTH = 20;
    localparam logic [19:0] DEF_HALT_WORD   = 20'hFFFFF;
    localparam logic [19:0] DEF_NOP_WORD    = 20'h00000;

    // Host loads are only safe while nothing is being issued to the CPU
    function automatic logic accepts_load(input seq_state_e s);
        return (s == S_IDLE) || (s == S_PAUSE) || (s == S_HALTED);
    endfunction

    // States in which an instruction is being fetched or presented
    function automatic logic is_busy(input seq_state_e s);
        return (s == S_FETCH) || (s == S_EXEC);
    endfunction

endpackage

// File: rtl/cpu_sequencer_prog_store.sv
// Program store: register array, one synchronous write port, one async read port.
// Every slot resets to the halt sentinel so unprogrammed addresses stop execution.
module prog_store #(
    parameter int                 WIDTH      = 20,
    parameter int                 ADDR_BITS  = 5,
    parameter logic [WIDTH-1:0]   RESET_WORD = '1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [ADDR_BITS-1:0]  waddr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic [ADDR_BITS-1:0]  raddr_i,
    output logic [WIDTH-1:0]      rdata_o
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Host write port; reset refills every slot with the sentinel
    // NOTE: this array is deliberately reset (flops, not RAM) because an
    // unprogrammed slot must read as the halt word after every reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                // NOTE: sequential state uses non-blocking assignments so all
                // flops update together at the edge regardless of statement order.
                mem_q[i] <= RESET_WORD;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction sequencer for simple_cpu: steps a PC through a host-loaded store,
// holds each word for STEP_CYCLES clocks, supports run / single-step / pause and
// stops on a sentinel word. All outputs come straight from flops.
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int                     INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter int                     PC_BITS     = 5,
    parameter int                     STEP_CYCLES = 4,
    parameter logic [INSTR_WIDTH-1:0] HALT_WORD   = DEF_HALT_WORD,
    parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = DEF_NOP_WORD
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_en,
    input  logic [PC_BITS-1:0]      load_addr,
    input  logic [INSTR_WIDTH-1:0]  load_data,
    input  logic                    start,
    input  logic                    step,
    input  logic                    stop,
    output logic [INSTR_WIDTH-1:0]  instruction,
    output logic                    cpu_rst,
    output logic [PC_BITS-1:0]      pc,
    output logic                    busy,
    output logic                    done
);

    localparam logic [CNT_W-1:0]   HOLD_INIT = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [PC_BITS-1:0] PC_ONE    = PC_BITS'(1);

    // Control state
    seq_state_e               state_q, state_d;
    logic                     single_q, single_d;     // 1: pause after each instruction
    logic                     stop_pend_q, stop_pend_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [PC_BITS-1:0]       pc_q, pc_d;

    // Registered outputs
    logic [INSTR_WIDTH-1:0]   instr_q, instr_d;
    logic                     cpu_rst_q, cpu_rst_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    // Store interface
    logic                     store_we;
    logic [INSTR_WIDTH-1:0]   store_rdata;

    // Command decode: stop outranks start, start outranks step
    logic go_run, go_step;
    assign go_run  = !stop && start;
    assign go_step = !stop && !start && step;

    // Loads are dropped while an instruction is in flight
    assign store_we = load_en && accepts_load(state_q);

    prog_store #(
        .WIDTH      (INSTR_WIDTH),
        .ADDR_BITS  (PC_BITS),
        .RESET_WORD (HALT_WORD)
    ) u_store (
        .clk     (clk),
        .rst     (rst),
        .we_i    (store_we),
        .waddr_i (load_addr),
        .wdata_i (load_data),
        .raddr_i (pc_q),
        .rdata_o (store_rdata)
    );

    // State register: FSM state, mode, stop flag, hold counter, PC and outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            single_q    <= 1'b0;
            stop_pend_q <= 1'b0;
            cnt_q       <= '0;
            pc_q        <= '0;
            instr_q     <= NOP_WORD;
            cpu_rst_q   <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            single_q    <= single_d;
            stop_pend_q <= stop_pend_d;
            cnt_q       <= cnt_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            cpu_rst_q   <= cpu_rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic: transitions, hold counting, PC advance, stop capture
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can
        // leave it unassigned and infer a latch.
        state_d     = state_q;
        single_d    = single_q;
        stop_pend_d = stop_pend_q;
        cnt_d       = cnt_q;
        pc_d        = pc_q;

        unique case (state_q)
            S_IDLE, S_PAUSE: begin
                if (go_run) begin
                    state_d  = S_FETCH;
                    single_d = 1'b0;
                end else if (go_step) begin
                    state_d  = S_FETCH;
                    single_d = 1'b1;
                end
            end

            S_FETCH: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (store_rdata == HALT_WORD) begin
                    state_d = S_HALTED;
                end else begin
                    state_d = S_EXEC;
                    cnt_d   = HOLD_INIT;
                end
            end

            S_EXEC: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    pc_d = pc_q + PC_ONE;
                    if (single_q || stop_pend_q || stop) begin
                        state_d     = S_PAUSE;
                        stop_pend_d = 1'b0;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            S_HALTED: begin
                if (go_run || go_step) begin
                    state_d  = S_FETCH;
                    single_d = go_step;
                    pc_d     = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic: derived from the next state so the flops show it on entry
    always_comb begin
        cpu_rst_d = (state_d == S_IDLE);
        busy_d    = is_busy(state_d);
        done_d    = (state_d == S_HALTED);
        instr_d   = NOP_WORD;
        if (state_d == S_EXEC) begin
            instr_d = (state_q == S_FETCH) ? store_rdata : instr_q;
        end
    end

    assign instruction = instr_q;
    assign cpu_rst     = cpu_rst_q;
    assign pc          = pc_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with default parameters.
module tb_cpu_sequencer;

    localparam logic [19:0] HALT = 20'hFFFFF;
    localparam logic [19:0] NOP  = 20'h00000;

    logic        clk;
    logic        rst;
    logic        load_en;
    logic [4:0]  load_addr;
    logic [19:0] load_data;
    logic        start;
    logic        step;
    logic        stop;
    logic [19:0] instruction;
    logic        cpu_rst;
    logic [4:0]  pc;
    logic        busy;
    logic        done;

    logic [27:0] obs;
    assign obs = {instruction, cpu_rst, pc, busy, done};

    int errors = 0;
    int checks = 0;

    logic [19:0] prog [3] = '{20'h12345, 20'h0ABCD, 20'hFFFFF};

    cpu_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .start       (start),
        .step        (step),
        .stop        (stop),
        .instruction (instruction),
        .cpu_rst     (cpu_rst),
        .pc          (pc),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output vectors {instruction, cpu_rst, pc, busy, done}
    function automatic logic [27:0] v_idle();
        return {NOP, 1'b1, 5'd0, 1'b0, 1'b0};
    endfunction
    function automatic logic [27:0] v_fetch(input logic [4:0] p);
        return {NOP, 1'b0, p, 1'b1, 1'b0};
    endfunction
    function automatic logic [27:0] v_exec(input logic [19:0] w, input logic [4:0] p);
        return {w, 1'b0, p, 1'b1, 1'b0};
    endfunction
    function automatic logic [27:0] v_pause(input logic [4:0] p);
        return {NOP, 1'b0, p, 1'b0, 1'b0};
    endfunction
    function automatic logic [27:0] v_halt(input logic [4:0] p);
        return {NOP, 1'b0, p, 1'b0, 1'b1};
    endfunction

    function automatic logic [19:0] wrap_word(input int i);
        return 20'hA0000 | 20'(i);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        start     = 1'b0;
        step      = 1'b0;
        stop      = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic load_word(input logic [4:0] a, input logic [19:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 3; i++) load_word(5'(i), prog[i]);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs !== v_idle()) begin
            errors++;
            $display("FAIL reset_outputs: got %h want %h", obs, v_idle());
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (dut.u_store.mem_q[i] !== HALT) begin
                errors++;
                $display("FAIL reset_store[%0d]: got %h want %h", i, dut.u_store.mem_q[i], HALT);
            end
        end
        tick();
        checks++;
        if (obs !== v_idle()) begin
            errors++;
            $display("FAIL reset_idle_hold: got %h want %h", obs, v_idle());
        end
    endtask

    task automatic test_run();
        logic [27:0] q [$];
        do_reset();
        load_prog();
        q.push_back(v_fetch(5'd0));
        repeat (4) q.push_back(v_exec(prog[0], 5'd0));
        q.push_back(v_fetch(5'd1));
        repeat (4) q.push_back(v_exec(prog[1], 5'd1));
        q.push_back(v_fetch(5'd2));
        repeat (2) q.push_back(v_halt(5'd2));
        start = 1'b1;
        tick();
        start = 1'b0;
        foreach (q[i]) begin
            if (i > 0) tick();
            checks++;
            if (obs !== q[i]) begin
                errors++;
                $display("FAIL run[%0d]: got %h want %h", i, obs, q[i]);
            end
        end
    endtask

    task automatic test_step();
        logic [27:0] q [$];
        do_reset();
        load_prog();
        for (int k = 0; k < 3; k++) begin
            q.delete();
            q.push_back(v_fetch(5'(k)));
            if (k < 2) begin
                repeat (4) q.push_back(v_exec(prog[k], 5'(k)));
                repeat (3) q.push_back(v_pause(5'(k + 1)));
            end else begin
                repeat (2) q.push_back(v_halt(5'd2));
            end
            step = 1'b1;
            tick();
            step = 1'b0;
            foreach (q[i]) begin
                if (i > 0) tick();
                checks++;
                if (obs !== q[i]) begin
                    errors++;
                    $display("FAIL step%0d[%0d]: got %h want %h", k, i, obs, q[i]);
                end
            end
        end
    endtask

    task automatic test_stop();
        logic [27:0] q [$];
        do_reset();
        load_prog();
        q.push_back(v_fetch(5'd0));
        repeat (4) q.push_back(v_exec(prog[0], 5'd0));
        repeat (2) q.push_back(v_pause(5'd1));
        start = 1'b1;
        tick();
        start = 1'b0;
        foreach (q[i]) begin
            if (i > 0) begin
                if (i == 3) stop = 1'b1;   // sampled at the end of the 2nd EXEC cycle
                tick();
                stop = 1'b0;
            end
            checks++;
            if (obs !== q[i]) begin
                errors++;
                $display("FAIL stop[%0d]: got %h want %h", i, obs, q[i]);
            end
        end
        q.delete();
        q.push_back(v_fetch(5'd1));
        repeat (4) q.push_back(v_exec(prog[1], 5'd1));
        q.push_back(v_fetch(5'd2));
        q.push_back(v_halt(5'd2));
        start = 1'b1;
        tick();
        start = 1'b0;
        foreach (q[i]) begin
            if (i > 0) tick();
            checks++;
            if (obs !== q[i]) begin
                errors++;
                $display("FAIL resume[%0d]: got %h want %h", i, obs, q[i]);
            end
        end
    endtask

    task automatic test_wrap_and_rst();
        do_reset();
        for (int i = 0; i < 32; i++) load_word(5'(i), wrap_word(i));
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (obs !== v_fetch(5'(i))) begin
                errors++;
                $display("FAIL wrap_fetch[%0d]: got %h want %h", i, obs, v_fetch(5'(i)));
            end
            for (int k = 0; k < 4; k++) begin
                tick();
                load_en = 1'b0;
                checks++;
                if (obs !== v_exec(wrap_word(i), 5'(i))) begin
                    errors++;
                    $display("FAIL wrap_exec[%0d.%0d]: got %h want %h", i, k, obs,
                             v_exec(wrap_word(i), 5'(i)));
                end
                if (i == 5 && k == 0) begin
                    // attempted overwrite of the next slot while busy
                    load_en   = 1'b1;
                    load_addr = 5'd6;
                    load_data = HALT;
                end
            end
            tick();
        end
        checks++;
        if (obs !== v_fetch(5'd0)) begin
            errors++;
            $display("FAIL wrap_refetch: got %h want %h", obs, v_fetch(5'd0));
        end
        tick();
        checks++;
        if (obs !== v_exec(wrap_word(0), 5'd0)) begin
            errors++;
            $display("FAIL wrap_reexec: got %h want %h", obs, v_exec(wrap_word(0), 5'd0));
        end
        // asynchronous reset in the middle of EXEC
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs !== v_idle()) begin
            errors++;
            $display("FAIL rst_async: got %h want %h", obs, v_idle());
        end
        @(posedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (dut.u_store.mem_q[i] !== HALT) begin
                errors++;
                $display("FAIL rst_store[%0d]: got %h want %h", i, dut.u_store.mem_q[i], HALT);
            end
        end
        tick();
        checks++;
        if (obs !== v_idle()) begin
            errors++;
            $display("FAIL rst_idle: got %h want %h", obs, v_idle());
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (obs !== v_fetch(5'd0)) begin
            errors++;
            $display("FAIL rst_fetch: got %h want %h", obs, v_fetch(5'd0));
        end
        tick();
        checks++;
        if (obs !== v_halt(5'd0)) begin
            errors++;
            $display("FAIL rst_halt: got %h want %h", obs, v_halt(5'd0));
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_step();
        test_stop();
        test_wrap_and_rst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
